pc_request_unit: RTL and testbench

//  Fetch stage and memory-request sequencer for the single-cycle MIPS core. Holds the PC,

---
 rtl/pc_request_unit_if.sv | 48 ++++
 rtl/pc_request_unit.sv | 126 ++++++++++++
 tb/tb_pc_request_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_request_unit_if.sv
// Fetch/data-memory handshake bundle between pc_request_unit and its environment.
// The retired-instruction count is present only when RETIRE_COUNT_EN is defined.
interface pc_request_unit_if;
    logic        ihit;
    logic        dhit;
    logic [31:0] imemload;
    logic        memread;
    logic        memwrite;
    logic        jump;
    logic [31:0] pcAddrOut;
    logic        jrsig;
    logic [31:0] rs_data;
    logic        beq;
    logic        bne;
    logic        alu_zero;
    logic [15:0] immOut;
    logic        halt;
    logic [31:0] imemaddr;
    logic        imemREN;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        halted;
`ifdef RETIRE_COUNT_EN
    logic [31:0] retired;
`endif

    // Fetch unit side: issues memory requests, consumes control decodes.
    modport master (
        input  ihit, dhit, imemload, memread, memwrite, jump, pcAddrOut,
               jrsig, rs_data, beq, bne, alu_zero, immOut, halt,
`ifdef RETIRE_COUNT_EN
        output retired,
`endif
        output imemaddr, imemREN, dmemREN, dmemWEN, instr, pc_plus4, halted
    );

    // Memory / control-unit side.
    modport slave (
        output ihit, dhit, imemload, memread, memwrite, jump, pcAddrOut,
               jrsig, rs_data, beq, bne, alu_zero, immOut, halt,
`ifdef RETIRE_COUNT_EN
        input  retired,
`endif
        input  imemaddr, imemREN, dmemREN, dmemWEN, instr, pc_plus4, halted
    );
endinterface

// File: rtl/pc_request_unit.sv
// Fetch stage and memory-request sequencer: holds the PC, fetches instructions,
// sequences one data access per LW/SW before the PC advances, and latches HALT.
// Optional feature macro: RETIRE_COUNT_EN adds a 32-bit retired-instruction counter.
module pc_request_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input logic             CLK,
    input logic             nRST,
    pc_request_unit_if.master bus
);

    typedef enum logic [1:0] {FETCH, DATA, HALTED} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        dmem_ren_q, dmem_ren_d;
    logic        dmem_wen_q, dmem_wen_d;
    logic        halted_q, halted_d;

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_target;
    logic        branch_taken;
    logic [31:0] next_pc;

`ifdef RETIRE_COUNT_EN
    logic [31:0] retired_q, retired_d;
    logic        retire;
`endif

    // State register: all sequential state with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= FETCH;
            pc_q       <= PC_INIT;
            dmem_ren_q <= 1'b0;
            dmem_wen_q <= 1'b0;
            halted_q   <= 1'b0;
`ifdef RETIRE_COUNT_EN
            retired_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            dmem_ren_q <= dmem_ren_d;
            dmem_wen_q <= dmem_wen_d;
            halted_q   <= halted_d;
`ifdef RETIRE_COUNT_EN
            retired_q  <= retired_d;
`endif
        end
    end

    // Next-PC selection: JR over J/JAL over taken branch over sequential.
    always_comb begin
        pc_plus4_w    = pc_q + 32'd4;
        branch_target = pc_plus4_w + {{14{bus.immOut[15]}}, bus.immOut, 2'b00};
        branch_taken  = (bus.beq & bus.alu_zero) | (bus.bne & ~bus.alu_zero);
        if (bus.jrsig)
            next_pc = bus.rs_data;
        else if (bus.jump)
            next_pc = bus.pcAddrOut;
        else if (branch_taken)
            next_pc = branch_target;
        else
            next_pc = pc_plus4_w;
    end

    // Next-state logic: fetch handshake, data-access sequencing and halt latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        dmem_ren_d = dmem_ren_q;
        dmem_wen_d = dmem_wen_q;
        halted_d   = halted_q;
        case (state_q)
            FETCH: begin
                if (bus.ihit) begin
                    if (bus.halt) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else if (bus.memread | bus.memwrite) begin
                        state_d    = DATA;
                        dmem_ren_d = bus.memread;
                        dmem_wen_d = bus.memwrite & ~bus.memread;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            DATA: begin
                if (bus.dhit) begin
                    state_d    = FETCH;
                    dmem_ren_d = 1'b0;
                    dmem_wen_d = 1'b0;
                    pc_d       = pc_plus4_w;
                end
            end
            HALTED: ;
            default: state_d = FETCH;
        endcase
    end

`ifdef RETIRE_COUNT_EN
    // Retire strobe: each PC update, plus the HALT instruction itself.
    always_comb begin
        retire    = ((state_q == FETCH) & bus.ihit & (bus.halt | ~(bus.memread | bus.memwrite)))
                  | ((state_q == DATA) & bus.dhit);
        retired_d = retired_q + {31'd0, retire};
    end
`endif

    // Output logic: fetch request only in FETCH; data requests are registered.
    always_comb begin
        bus.imemaddr = pc_q;
        bus.imemREN  = (state_q == FETCH);
        bus.dmemREN  = dmem_ren_q;
        bus.dmemWEN  = dmem_wen_q;
        bus.instr    = bus.imemload;
        bus.pc_plus4 = pc_plus4_w;
        bus.halted   = halted_q;
`ifdef RETIRE_COUNT_EN
        bus.retired  = retired_q;
`endif
    end

endmodule

// File: tb/tb_pc_request_unit.sv
// Self-checking bench for pc_request_unit: directed scenarios plus a randomized
// phase, all compared against a transaction-level reference model.
module tb_pc_request_unit;

    localparam logic [31:0] TB_PC_INIT = 32'h0000_0000;
    localparam logic [31:0] ADDU_WORD  = 32'h0022_1821;

    logic CLK;
    logic nRST;
    pc_request_unit_if bus ();

    pc_request_unit #(.PC_INIT(TB_PC_INIT)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: PC, whether a data access is outstanding, halted flag.
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    bit          m_wait_data;
    bit          m_halted;
    bit          m_ren;
    bit          m_wen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc        = TB_PC_INIT;
        m_ret       = 32'd0;
        m_wait_data = 1'b0;
        m_halted    = 1'b0;
        m_ren       = 1'b0;
        m_wen       = 1'b0;
    endtask

    function automatic logic [31:0] m_target();
        logic [31:0] off;
        off = 32'($signed(bus.immOut)) * 4;
        if (bus.jrsig)                                                  return bus.rs_data;
        if (bus.jump)                                                   return bus.pcAddrOut;
        if ((bus.beq && bus.alu_zero) || (bus.bne && !bus.alu_zero))    return m_pc + 4 + off;
        return m_pc + 4;
    endfunction

    task automatic model_step();
        if (m_halted) begin
            // frozen until reset
        end else if (m_wait_data) begin
            if (bus.dhit) begin
                m_wait_data = 1'b0;
                m_ren = 1'b0;
                m_wen = 1'b0;
                m_pc  = m_pc + 4;
                m_ret = m_ret + 1;
            end
        end else if (bus.ihit) begin
            if (bus.halt) begin
                m_halted = 1'b1;
                m_ret    = m_ret + 1;
            end else if (bus.memread || bus.memwrite) begin
                m_wait_data = 1'b1;
                m_ren = bus.memread;
                m_wen = bus.memwrite && !bus.memread;
            end else begin
                m_pc  = m_target();
                m_ret = m_ret + 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("imemaddr", bus.imemaddr, m_pc);
        chk("imemREN",  {31'd0, bus.imemREN}, {31'd0, !m_halted && !m_wait_data});
        chk("dmemREN",  {31'd0, bus.dmemREN}, {31'd0, m_ren});
        chk("dmemWEN",  {31'd0, bus.dmemWEN}, {31'd0, m_wen});
        chk("instr",    bus.instr, bus.imemload);
        chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        chk("halted",   {31'd0, bus.halted}, {31'd0, m_halted});
`ifdef RETIRE_COUNT_EN
        chk("retired",  bus.retired, m_ret);
`endif
    endtask

    // One clock: check settled outputs, advance the model at the edge, return to negedge.
    task automatic tick();
        #1;
        check_outputs();
        @(posedge CLK);
        if (nRST) model_step();
        else      model_reset();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.ihit      = 1'b1;
        bus.dhit      = 1'b0;
        bus.imemload  = ADDU_WORD;
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.jump      = 1'b0;
        bus.pcAddrOut = 32'd0;
        bus.jrsig     = 1'b0;
        bus.rs_data   = 32'd0;
        bus.beq       = 1'b0;
        bus.bne       = 1'b0;
        bus.alu_zero  = 1'b0;
        bus.immOut    = 16'd0;
        bus.halt      = 1'b0;
    endtask

    task automatic rand_inputs(input bit allow_halt);
        bus.ihit      = ($urandom_range(3) != 0);
        bus.dhit      = $urandom_range(1) == 1;
        bus.imemload  = $urandom;
        bus.memread   = ($urandom_range(7) == 0);
        bus.memwrite  = ($urandom_range(7) == 0);
        bus.jump      = ($urandom_range(7) == 0);
        bus.pcAddrOut = $urandom;
        bus.jrsig     = ($urandom_range(7) == 0);
        bus.rs_data   = $urandom;
        bus.beq       = ($urandom_range(3) == 0);
        bus.bne       = ($urandom_range(3) == 0);
        bus.alu_zero  = $urandom_range(1) == 1;
        bus.immOut    = 16'($urandom);
        bus.halt      = allow_halt && ($urandom_range(3) == 0);
    endtask

    initial begin
        nRST = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge CLK);
        tick();
        chk("reset_pc", bus.imemaddr, TB_PC_INIT);
        nRST = 1'b1;

        // Sequential ADDU stream
        chk("seq_pc0", bus.imemaddr, 32'h0); tick();
        chk("seq_pc4", bus.imemaddr, 32'h4); tick();
        chk("seq_pc8", bus.imemaddr, 32'h8);

        // Fetch stall
        bus.ihit = 1'b0;
        repeat (3) begin tick(); chk("stall_pc8", bus.imemaddr, 32'h8); end
        bus.ihit = 1'b1; tick();
        chk("stall_pcC", bus.imemaddr, 32'hC);
        tick();
        chk("pc10", bus.imemaddr, 32'h10);

        // LW with dhit in the second data cycle
        bus.memread = 1'b1; tick();
        bus.memread = 1'b0; bus.ihit = 1'b0;
        chk("lw_ren1", {31'd0, bus.dmemREN}, 32'd1);
        chk("lw_iren", {31'd0, bus.imemREN}, 32'd0);
        tick();
        chk("lw_ren2", {31'd0, bus.dmemREN}, 32'd1);
        bus.dhit = 1'b1; tick();
        bus.dhit = 1'b0; bus.ihit = 1'b1;
        chk("lw_pc14", bus.imemaddr, 32'h14);
        chk("lw_ren_off", {31'd0, bus.dmemREN}, 32'd0);

        // BEQ taken / not taken at pc 20
        repeat (3) tick();
        chk("pc20", bus.imemaddr, 32'h20);
        bus.beq = 1'b1; bus.immOut = 16'hFFFE; bus.alu_zero = 1'b1; tick();
        chk("beq_taken", bus.imemaddr, 32'h1C);
        bus.beq = 1'b0; tick();
        bus.beq = 1'b1; bus.alu_zero = 1'b0; tick();
        chk("beq_not_taken", bus.imemaddr, 32'h24);
        bus.beq = 1'b0;

        // JR priority over J
        bus.jump = 1'b1; bus.jrsig = 1'b1; bus.rs_data = 32'h40; bus.pcAddrOut = 32'h80; tick();
        chk("jr_prio", bus.imemaddr, 32'h40);
        bus.jrsig = 1'b0; tick();
        chk("jump", bus.imemaddr, 32'h80);
        bus.jump = 1'b0;

        // memread and memwrite together: read wins
        bus.memread = 1'b1; bus.memwrite = 1'b1; tick();
        bus.memread = 1'b0; bus.memwrite = 1'b0;
        chk("both_wen", {31'd0, bus.dmemWEN}, 32'd0);
        chk("both_ren", {31'd0, bus.dmemREN}, 32'd1);
        bus.dhit = 1'b1; tick(); bus.dhit = 1'b0;
        chk("both_pc", bus.imemaddr, 32'h84);

        // SW
        bus.memwrite = 1'b1; tick(); bus.memwrite = 1'b0;
        chk("sw_wen", {31'd0, bus.dmemWEN}, 32'd1);
        bus.dhit = 1'b1; tick(); bus.dhit = 1'b0;
        chk("sw_pc", bus.imemaddr, 32'h88);

        // Wrap-around and misaligned target
        bus.jump = 1'b1; bus.pcAddrOut = 32'hFFFF_FFFC; tick(); bus.jump = 1'b0;
        tick();
        chk("wrap_pc", bus.imemaddr, 32'h0);
        bus.jrsig = 1'b1; bus.rs_data = 32'h13; tick(); bus.jrsig = 1'b0;
        tick();
        chk("misaligned_pc", bus.imemaddr, 32'h17);

        // Reset while a read is outstanding drops the request immediately
        bus.memread = 1'b1; tick();
        bus.memread = 1'b0; bus.ihit = 1'b0;
        chk("pre_rst_ren", {31'd0, bus.dmemREN}, 32'd1);
        nRST = 1'b0; #1;
        model_reset();
        chk("rst_data_ren", {31'd0, bus.dmemREN}, 32'd0);
        tick();
        nRST = 1'b1;
        idle_inputs();

        // Randomized phase
        repeat (400) begin rand_inputs(1'b0); tick(); end
        idle_inputs();
        bus.dhit = 1'b1; tick();
        bus.dhit = 1'b0;

        // HALT at pc 30
        bus.jump = 1'b1; bus.pcAddrOut = 32'h30; tick(); bus.jump = 1'b0;
        chk("pc30", bus.imemaddr, 32'h30);
        bus.halt = 1'b1; tick(); bus.halt = 1'b0;
        chk("halted", {31'd0, bus.halted}, 32'd1);
        chk("halt_iren", {31'd0, bus.imemREN}, 32'd0);
        repeat (10) begin rand_inputs(1'b1); tick(); end
        chk("halt_frozen", bus.imemaddr, 32'h30);
        idle_inputs();

        // Reset pulse leaves HALTED
        nRST = 1'b0; #1;
        model_reset();
        check_outputs();
        tick();
        nRST = 1'b1;
        chk("post_rst_pc", bus.imemaddr, TB_PC_INIT);
        chk("post_rst_halted", {31'd0, bus.halted}, 32'd0);
`ifdef RETIRE_COUNT_EN
        chk("post_rst_retired", bus.retired, 32'd0);
`endif
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
